// File: rtl/adsb_tx_gen_if.sv
// Control/data bundle between the ADS-B burst generator and whatever drives it
// (SPI register block or testbench).
interface adsb_tx_gen_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             abort;
    logic             long_msg;
    logic [111:0]     msg;
    logic [WIDTH-1:0] hi_level;
    logic [WIDTH-1:0] lo_level;
    logic [WIDTH-1:0] logmag;
    logic             pulse;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, long_msg, msg, hi_level, lo_level,
        input  logmag, pulse, busy, done
    );

    modport slave (
        input  start, abort, long_msg, msg, hi_level, lo_level,
        output logmag, pulse, busy, done
    );
endinterface

// File: rtl/adsb_tx_gen.sv
// Mode-S / ADS-B burst generator: turns a latched 56/112-bit message into a
// PPM log-magnitude sample stream (preamble + data) at 20 samples per bit.
module adsb_tx_gen #(
    parameter int WIDTH    = 10,
    parameter int HALF_BIT = 10
) (
    input  logic          clk,
    input  logic          reset,
    adsb_tx_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;

    localparam logic [7:0] PRE_LAST = 8'(16 * HALF_BIT - 1);
    localparam logic [4:0] S_LAST   = 5'(2 * HALF_BIT - 1);
    localparam logic [4:0] S_HALF   = 5'(HALF_BIT);
    // Preamble pulses occupy half-bit slots 0, 2, 7 and 9.
    localparam logic [7:0] PH1  = 8'(1 * HALF_BIT);
    localparam logic [7:0] PH2  = 8'(2 * HALF_BIT);
    localparam logic [7:0] PH3  = 8'(3 * HALF_BIT);
    localparam logic [7:0] PH7  = 8'(7 * HALF_BIT);
    localparam logic [7:0] PH8  = 8'(8 * HALF_BIT);
    localparam logic [7:0] PH9  = 8'(9 * HALF_BIT);
    localparam logic [7:0] PH10 = 8'(10 * HALF_BIT);

    state_t           r_state;
    logic [7:0]       r_pcnt;
    logic [4:0]       r_scnt;
    logic [6:0]       r_bcnt;
    logic [111:0]     r_shift;
    logic             r_long;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_fin;
    logic [WIDTH-1:0] r_logmag;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_next;
    logic [7:0]       w_pcnt_next;
    logic [4:0]       w_scnt_next;
    logic [6:0]       w_bcnt_next;
    logic [111:0]     w_shift_next;
    logic             w_long_next;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_fin_next;
    logic [6:0]       w_bit_last;
    logic             w_pre_pulse;
    logic [WIDTH-1:0] w_logmag;
    logic             w_pulse;
    logic             w_busy;
    logic             w_done;

    assign w_bit_last  = r_long ? 7'd111 : 7'd55;
    assign w_pre_pulse = (r_pcnt < PH1)
                      || (r_pcnt >= PH2 && r_pcnt < PH3)
                      || (r_pcnt >= PH7 && r_pcnt < PH8)
                      || (r_pcnt >= PH9 && r_pcnt < PH10);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_scnt   <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_long   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_fin    <= 1'b0;
            r_logmag <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pcnt   <= w_pcnt_next;
            r_scnt   <= w_scnt_next;
            r_bcnt   <= w_bcnt_next;
            r_shift  <= w_shift_next;
            r_long   <= w_long_next;
            r_hi     <= w_hi_next;
            r_lo     <= w_lo_next;
            r_fin    <= w_fin_next;
            r_logmag <= w_logmag;
            r_pulse  <= w_pulse;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        w_scnt_next  = r_scnt;
        w_bcnt_next  = r_bcnt;
        w_shift_next = r_shift;
        w_long_next  = r_long;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_fin_next   = 1'b0;
        if (bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next = S_PRE;
                        w_pcnt_next  = '0;
                        w_shift_next = bus.msg;
                        w_long_next  = bus.long_msg;
                        w_hi_next    = bus.hi_level;
                        w_lo_next    = bus.lo_level;
                    end
                end
                S_PRE: begin
                    if (r_pcnt == PRE_LAST) begin
                        w_state_next = S_DATA;
                        w_scnt_next  = '0;
                        w_bcnt_next  = '0;
                    end else begin
                        w_pcnt_next = r_pcnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (r_scnt == S_LAST) begin
                        w_scnt_next  = '0;
                        w_shift_next = {r_shift[110:0], 1'b0};
                        if (r_bcnt == w_bit_last) begin
                            w_state_next = S_IDLE;
                            w_fin_next   = 1'b1;
                        end else begin
                            w_bcnt_next = r_bcnt + 7'd1;
                        end
                    end else begin
                        w_scnt_next = r_scnt + 5'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the current state, so they trail the FSM by
    // one edge; r_fin carries the completion into the first visible idle sample.
    always_comb begin
        w_pulse  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_logmag = bus.lo_level;
        case (r_state)
            S_IDLE: w_done = r_fin;
            S_PRE: begin
                w_busy  = 1'b1;
                w_pulse = w_pre_pulse;
            end
            S_DATA: begin
                w_busy  = 1'b1;
                w_pulse = r_shift[111] ? (r_scnt < S_HALF) : (r_scnt >= S_HALF);
            end
            default: ;
        endcase
        if (w_busy)
            w_logmag = w_pulse ? r_hi : r_lo;
        if (bus.abort && r_state != S_IDLE) begin
            w_busy   = 1'b0;
            w_pulse  = 1'b0;
            w_logmag = r_lo;
        end
    end

    assign bus.logmag = r_logmag;
    assign bus.pulse  = r_pulse;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_adsb_tx_gen.sv
// Directed bench for adsb_tx_gen: captures each burst sample by sample and
// compares it against hand-derived preamble/data timing.
module tb_adsb_tx_gen;
    localparam logic [111:0] LONG_MSG  = 112'h8D4840D6202CC371C32CE0576098;
    localparam logic [55:0]  SHORT_MSG = 56'h5D4840D6AB1234;
    localparam int           NCAP      = 5000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic       cap_busy  [0:NCAP-1];
    logic       cap_pulse [0:NCAP-1];
    logic       cap_done  [0:NCAP-1];
    logic [9:0] cap_lm    [0:NCAP-1];

    adsb_tx_gen_if #(.WIDTH(10)) bus ();

    adsb_tx_gen #(.WIDTH(10), .HALF_BIT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // kind: 0 none, 1 start pulse, 2 abort pulse, 3 assert reset, 4 corrupt inputs
    task automatic run(input int n, input int act_at, input int kind);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_busy[c]  = bus.busy;
            cap_pulse[c] = bus.pulse;
            cap_done[c]  = bus.done;
            cap_lm[c]    = bus.logmag;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (c == act_at) begin
                case (kind)
                    1: bus.start = 1'b1;
                    2: bus.abort = 1'b1;
                    3: begin
                        reset = 1'b0;
                        #1;
                        check("rst_async_busy",  160'(bus.busy),   160'(0));
                        check("rst_async_pulse", 160'(bus.pulse),  160'(0));
                        check("rst_async_lm",    160'(bus.logmag), 160'(0));
                    end
                    4: begin
                        bus.hi_level = 10'd555;
                        bus.lo_level = 10'd7;
                        bus.msg      = '0;
                        bus.long_msg = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    function automatic int busy_count(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (cap_busy[i]) k++;
        return k;
    endfunction

    function automatic int done_count(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (cap_done[i]) k++;
        return k;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (cap_done[i]) return i;
        return 9999;
    endfunction

    // Receiver-style decode: compare the two half-bit centres of each bit.
    function automatic logic [111:0] decode(input int nbits);
        logic [111:0] v = '0;
        for (int i = 0; i < nbits; i++)
            v = {v[110:0], cap_pulse[160 + 20*i + 5]};
        return v;
    endfunction

    function automatic int manch_bad(input int nbits);
        int k = 0;
        for (int i = 0; i < nbits; i++)
            if (cap_pulse[160 + 20*i + 5] == cap_pulse[160 + 20*i + 15]) k++;
        return k;
    endfunction

    function automatic int level_bad(input int n, input logic [9:0] hi, input logic [9:0] lo);
        int k = 0;
        for (int i = 0; i < n; i++)
            if (cap_busy[i] && cap_lm[i] != (cap_pulse[i] ? hi : lo)) k++;
        return k;
    endfunction

    function automatic logic [159:0] pre_obs();
        logic [159:0] v = '0;
        for (int p = 0; p < 160; p++) v[p] = cap_pulse[p];
        return v;
    endfunction

    function automatic logic [159:0] pre_exp();
        logic [159:0] v = '0;
        for (int p = 0; p < 160; p++)
            v[p] = (p < 10) || (p >= 20 && p < 30) || (p >= 70 && p < 80) || (p >= 90 && p < 100);
        return v;
    endfunction

    task automatic set_long();
        bus.long_msg = 1'b1;
        bus.msg      = LONG_MSG;
        bus.hi_level = 10'd800;
        bus.lo_level = 10'd100;
    endtask

    initial begin
        int idle_busy;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_long();
        repeat (3) @(negedge clk);
        check("reset_busy",   160'(bus.busy),   160'(0));
        check("reset_done",   160'(bus.done),   160'(0));
        check("reset_pulse",  160'(bus.pulse),  160'(0));
        check("reset_logmag", 160'(bus.logmag), 160'(0));
        reset = 1'b1;
        @(negedge clk);
        check("idle_logmag", 160'(bus.logmag), 160'(100));

        // Long burst; inputs scrambled mid-burst must not leak in.
        run(2450, 100, 4);
        check("long_busy_len",   160'(busy_count(2450)), 160'(2400));
        check("long_preamble",   pre_obs(), pre_exp());
        check("long_lm_first",   160'(cap_lm[0]),  160'(800));
        check("long_lm_gap",     160'(cap_lm[10]), 160'(100));
        check("long_bit0_first", 160'(cap_pulse[160]), 160'(1));
        check("long_bit0_second",160'(cap_pulse[170]), 160'(0));
        check("long_decode",     160'(decode(112)), 160'(LONG_MSG));
        check("long_manchester", 160'(manch_bad(112)), 160'(0));
        check("long_levels",     160'(level_bad(2450, 10'd800, 10'd100)), 160'(0));
        check("long_done_idx",   160'(first_done(2450)), 160'(2400));
        check("long_done_cnt",   160'(done_count(2450)), 160'(1));
        check("long_done_lm",    160'(cap_lm[2400]), 160'(7));

        // Short message; low half of msg must be ignored.
        bus.long_msg = 1'b0;
        bus.msg      = {SHORT_MSG, 56'hFFFFFFFFFFFFFF};
        bus.hi_level = 10'd800;
        bus.lo_level = 10'd100;
        run(1300, -1, 0);
        check("short_busy_len", 160'(busy_count(1300)), 160'(1280));
        check("short_decode",   160'(decode(56)), 160'(SHORT_MSG));
        check("short_b55_1269", 160'(cap_pulse[1269]), 160'(0));
        check("short_b55_1270", 160'(cap_pulse[1270]), 160'(1));
        check("short_done_idx", 160'(first_done(1300)), 160'(1280));

        // start while busy is ignored
        set_long();
        run(2450, 499, 1);
        check("restart_busy_len", 160'(busy_count(2450)), 160'(2400));
        check("restart_done_cnt", 160'(done_count(2450)), 160'(1));

        // start coinciding with the done sample: back-to-back bursts
        run(4850, 2399, 1);
        check("b2b_done",      160'(cap_done[2400]), 160'(1));
        check("b2b_gap_busy",  160'(cap_busy[2400]), 160'(0));
        check("b2b_gap_lm",    160'(cap_lm[2400]),   160'(100));
        check("b2b_next_busy", 160'(cap_busy[2401]), 160'(1));
        check("b2b_next_lm",   160'(cap_lm[2401]),   160'(800));
        check("b2b_busy_len",  160'(busy_count(4850)), 160'(4800));
        check("b2b_done_cnt",  160'(done_count(4850)), 160'(2));

        // abort with the FSM at preamble sample 75
        run(300, 74, 2);
        check("abort_pre_pulse", 160'(cap_pulse[74]), 160'(1));
        check("abort_busy",      160'(cap_busy[75]),  160'(0));
        check("abort_pulse",     160'(cap_pulse[75]), 160'(0));
        check("abort_lm",        160'(cap_lm[75]),    160'(100));
        check("abort_no_done",   160'(done_count(300)), 160'(0));

        // abort and start together from idle
        @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
        idle_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
        end
        check("abort_start_idle", 160'(idle_busy), 160'(0));

        // reset mid-data (bit 40 of a short message), then a clean long burst
        bus.long_msg = 1'b0;
        bus.msg      = {SHORT_MSG, 56'h0};
        run(1000, 959, 3);
        check("rst_no_done", 160'(done_count(1000)), 160'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        set_long();
        run(2450, -1, 0);
        check("post_rst_busy_len", 160'(busy_count(2450)), 160'(2400));
        check("post_rst_decode",   160'(decode(112)), 160'(LONG_MSG));
        check("post_rst_done_idx", 160'(first_done(2450)), 160'(2400));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adsb_tx_gen.md
Name: adsb_tx_gen

Overview:
- ADS-B / Mode-S burst generator: the transmit side of the 1090 MHz receive chain.
- Converts a latched 56- or 112-bit message into a pulse-position-modulated log-magnitude sample stream at 20 MS/s (1 bit = 20 samples, half-bit = 10), including the standard 8 us preamble.
- Sits in the top level beside the receiver; the top muxes its output into the receiver's log-magnitude input for loopback and self-test, with message and levels written over SPI.

Parameters:
- width, 10, bit width of the hi_level, lo_level and logmag sample buses.
- half_bit, 10, samples per half-bit (0.5 us at 20 MHz clock).

Ports:
- clk  input  1  system clock, 20 MHz.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- start  input  1  single-cycle request to transmit one burst.
- abort  input  1  single-cycle request to terminate the burst in progress.
- long_msg  input  1  1 = 112-bit extended squitter, 0 = 56-bit short message.
- msg  input  112  message; MSB (bit 111) transmitted first; short message uses msg[111:56].
- hi_level  input  width  sample value while a pulse is on.
- lo_level  input  width  sample value while a pulse is off (noise floor).
- logmag  output  width  generated log-magnitude sample stream (registered).
- pulse  output  1  1 while logmag = hi_level (ideal envelope, for bench compare).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on normal burst completion.

Behaviour:
Reset:
- State IDLE; busy=0, done=0, pulse=0; logmag=0 until the first clk edge after reset release, then lo_level.

State machine: IDLE, PREAMBLE, DATA.

IDLE:
- logmag=lo_level, pulse=0.
- start=1 at edge N: latch msg, long_msg, hi_level and lo_level into shadow registers; go to PREAMBLE.
- At edge N+1 busy=1 and the first preamble sample appears on logmag.
- Input changes after edge N do not affect the burst in progress.

PREAMBLE:
- 160 samples, index p=0..159.
- pulse=1 for p in 0-9, 20-29, 70-79 and 90-99; 0 otherwise.
- After p=159 go to DATA.

DATA:
- Bit counter b=0..L-1, where L=112 (long) or 56 (short).
- Sample counter s=0..19 within each bit.
- Bit value 1: pulse=1 for s=0-9. Bit value 0: pulse=1 for s=10-19.
- Bits come from a left-shifting 112-bit register, MSB first.
- After b=L-1, s=19: return to IDLE. In the first IDLE cycle busy=0, done=1 for exactly one cycle, logmag=lo_level.

Output timing:
- logmag = pulse ? hi_level_shadow : lo_level_shadow, registered in the same cycle as pulse.
- Burst length: long 2400 cycles of busy=1; short 1280 cycles.

Start handling:
- start while busy=1 is ignored; no queueing.
- start in the done cycle (busy=0) is accepted, giving back-to-back bursts with one lo_level sample between them.

Abort:
- abort=1 in any state: next edge goes to IDLE, busy=0, pulse=0, logmag=lo_level_shadow, done stays 0.
- abort and start in the same cycle: abort wins, no burst starts.

Level and counter rules:
- hi_level < lo_level is legal; output values are not checked or clamped.
- Counters are sized exactly: 8-bit preamble counter, 5-bit sample counter, 7-bit bit counter. No wrap-around is reachable.
- reset low mid-burst: immediate return to reset state, done not asserted.

Test Plan:
- Reset, then hi_level=800, lo_level=100, long_msg=1, msg=112'h8D4840D6202CC371C32CE0576098, start pulse: busy high exactly 2400 cycles; pulse=1 at preamble offsets 0-9, 20-29, 70-79, 90-99; first data bit (1) high at samples 160-169; done pulses once; a receiver loopback decodes the identical 112 bits.
- Short message, msg[111:56]=56'h5D4840D6AB1234, long_msg=0: busy for 1280 cycles; sample 160+20*55+10 = 1270 onward follows bit 56 (value 0 → second half high); done at cycle 1281.
- start asserted again at cycle 500 of a long burst: ignored, burst length still 2400, a single done.
- start asserted in the done cycle: second burst begins next edge, with exactly one lo_level sample between bursts.
- abort at preamble sample 75: next cycle logmag=lo_level, busy=0, done never asserts. abort and start together from IDLE: no burst.
- reset driven low at data bit 40: outputs clear asynchronously. After release, start produces a clean full burst.
